// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmit channel among NUM_REQ byte-stream
// requesters. Grants are round-robin at packet granularity, so a packet is
// sent whole before another requester can reach the line. Each byte is paced
// against the transmitter: write, wait for busy to rise (or a latency bound),
// then wait for busy to fall before the next byte.
//
// Requester handshake (valid/ready): a byte moves on a rising clk edge where
// req_valid[i] and req_ready[i] are both 1. A requester holding valid=1 must
// keep req_data/req_last stable until ready=1. Dropping valid while ready=0
// is allowed. req_ready is combinational and only ever set for the current
// grantee, in SEND, while the transmitter is idle.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int BUSY_LAT    = 8,
  parameter int PKT_TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   wr_en,
  output logic [7:0]             wr_data,
  input  logic                   tx_busy,
  output logic                   grant_valid,
  output logic [ID_W-1:0]        grant_id,
  output logic                   timeout_pulse,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic            last_flag;
  logic [7:0]      hi_cnt;
  logic [15:0]     idle_cnt;

  logic [7:0]      data_arr [NUM_REQ];
  logic            arb_found;
  logic [ID_W-1:0] arb_idx;
  int              cand;
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_data;
  logic            accept;
  logic            idle_expire;
  logic            hi_last;

  assign state_dbg = state;

  // Split the flat data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[8*i +: 8];
    end
  end

  // Round-robin search: first valid requester after rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!arb_found && req_valid[ID_W'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = ID_W'(cand);
      end
    end
  end

  // Grantee view of the request bus and the per-state conditions.
  always_comb begin
    g_valid     = req_valid[grant_id];
    g_last      = req_last[grant_id];
    g_data      = data_arr[grant_id];
    accept      = (state == ST_SEND) && g_valid && !tx_busy;
    idle_expire = (PKT_TIMEOUT != 0) && (state == ST_SEND) && !g_valid &&
                  (({1'b0, idle_cnt} + 17'd1) == 17'(PKT_TIMEOUT));
    hi_last     = (hi_cnt == 8'(BUSY_LAT - 1));
  end

  // Ready goes only to the grantee, and is held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rstb && (state == ST_SEND)) begin
      req_ready[grant_id] = g_valid & ~tx_busy;
    end
  end

  // Main sequencer: arbitrate, accept a byte, pace it against tx_busy.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state         <= ST_IDLE;
      rr_ptr        <= ID_W'(NUM_REQ - 1);
      last_flag     <= 1'b0;
      hi_cnt        <= '0;
      idle_cnt      <= '0;
      wr_en         <= 1'b0;
      wr_data       <= '0;
      grant_valid   <= 1'b0;
      grant_id      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      wr_en         <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_found) begin
            grant_id    <= arb_idx;
            grant_valid <= 1'b1;
            idle_cnt    <= '0;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (accept) begin
            wr_data   <= g_data;
            wr_en     <= 1'b1;
            last_flag <= g_last;
            idle_cnt  <= '0;
            hi_cnt    <= '0;
            state     <= ST_WAIT_HI;
          end else if (idle_expire) begin
            // Grantee went quiet mid-packet for too long: free the line.
            timeout_pulse <= 1'b1;
            grant_valid   <= 1'b0;
            rr_ptr        <= grant_id;
            idle_cnt      <= '0;
            state         <= ST_IDLE;
          end else if ((PKT_TIMEOUT != 0) && !g_valid) begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
        ST_WAIT_HI: begin
          // Leave on busy, or once BUSY_LAT cycles have passed; the count
          // stops at BUSY_LAT so it can never wrap.
          if (tx_busy) begin
            state <= ST_WAIT_LO;
          end else if (hi_last) begin
            hi_cnt <= 8'(BUSY_LAT);
            state  <= ST_WAIT_LO;
          end else begin
            hi_cnt <= hi_cnt + 8'd1;
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            if (last_flag) begin
              rr_ptr      <= grant_id;
              grant_valid <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              idle_cnt <= '0;
              state    <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte sources, a simple UART busy
// model, and a scoreboard of {grant_id, byte} expected on each wr_en strobe.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int BUSY_LAT    = 8;
  localparam int PKT_TIMEOUT = 16;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_WAIT_HI = 2'd2;
  localparam logic [1:0] S_WAIT_LO = 2'd3;

  logic                 clk;
  logic                 rstb;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 wr_en;
  logic [7:0]           wr_data;
  logic                 tx_busy;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
  logic                 timeout_pulse;
  logic [1:0]           state_dbg;

  int checks = 0;
  int errors = 0;

  logic [ID_W+7:0] exp_q[$];
  logic [8:0]      src_q[NUM_REQ][$];

  int   busy_len = 20;
  bit   busy_en  = 1'b1;
  int   busy_left;
  int   cyc = 0;
  int   wr_count = 0;
  int   last_wr_cyc = 0;
  int   gv_fall_cyc = 0;
  int   hi_cycles = 0;
  int   ready_viol = 0;
  int   gid_hist[$];
  int   wr_cyc_q[$];
  bit   prev_gv = 1'b0;
  logic [NUM_REQ-1:0] fire;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .BUSY_LAT(BUSY_LAT), .PKT_TIMEOUT(PKT_TIMEOUT)
  ) dut (
    .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wr_en(wr_en), .wr_data(wr_data),
    .tx_busy(tx_busy), .grant_valid(grant_valid), .grant_id(grant_id),
    .timeout_pulse(timeout_pulse), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // UART busy model: busy rises one cycle after wr_en, stays busy_len cycles
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tx_busy   <= 1'b0;
      busy_left <= 0;
    end else if (busy_en && wr_en) begin
      tx_busy   <= 1'b1;
      busy_left <= busy_len - 1;
    end else if (tx_busy) begin
      if (busy_left > 0) busy_left <= busy_left - 1;
      else tx_busy <= 1'b0;
    end
  end

  // Driver: present queue heads; pop a byte after a valid&ready edge
  initial begin
    logic [8:0] head;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fire[i] && src_q[i].size() > 0) head = src_q[i].pop_front();
        if (src_q[i].size() > 0) begin
          head = src_q[i][0];
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = head[7:0];
          req_last[i]        = head[8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard on wr_en, grant history, ready exclusivity
  always @(negedge clk) begin
    logic [ID_W+7:0]    e;
    logic [NUM_REQ-1:0] mask;
    cyc++;
    if (rstb) begin
      if (wr_en) begin
        wr_count++;
        wr_cyc_q.push_back(cyc);
        last_wr_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got id=%0d data=%02h, required no write", grant_id, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({grant_id, wr_data} !== e) begin
            errors++;
            $display("FAIL wr_byte: got id=%0d data=%02h, required id=%0d data=%02h",
                     grant_id, wr_data, e[ID_W+7:8], e[7:0]);
          end
        end
      end
      if (state_dbg == S_WAIT_HI) hi_cycles++;
      if (grant_valid && !prev_gv) gid_hist.push_back(int'(grant_id));
      if (!grant_valid && prev_gv) gv_fall_cyc = cyc;
      mask = req_ready;
      if (grant_valid) mask[grant_id] = 1'b0;
      if (mask != '0) ready_viol++;
    end
    prev_gv = grant_valid;
  end

  function automatic bit src_empty();
    for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_byte(input int r, input logic [7:0] d, input logic last, input bit expect_wr);
    src_q[r].push_back({last, d});
    if (expect_wr) exp_q.push_back({ID_W'(r), d});
  endtask

  task automatic wait_drain(input int budget, output bit done);
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && src_empty() && req_valid == '0 &&
          state_dbg == S_IDLE && !grant_valid && !tx_busy) done = 1'b1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    bit done;
    int h0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b, required 0", wr_en); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_wr_data: got %02h, required 00", wr_data); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rst_grant_valid: got %b, required 0", grant_valid); end
    checks++; if (grant_id !== '0) begin errors++; $display("FAIL rst_grant_id: got %0d, required 0", grant_id); end
    checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b, required 0", timeout_pulse); end
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL rst_state: got %0d, required 0", state_dbg); end
    busy_len = 4;
    h0 = gid_hist.size();
    push_byte(3, 8'h5A, 1'b1, 1'b1);
    push_byte(0, 8'h0A, 1'b1, 1'b0);
    exp_q.push_front({ID_W'(0), 8'h0A});
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_ready: got %b, required 0000", req_ready); end
    @(negedge clk);
    rstb = 1'b1;
    wait_drain(500, done);
    checks++; if (!done) begin errors++; $display("FAIL rst_drain: got no drain, required drain"); end
    checks++;
    if (gid_hist.size() < h0 + 1 || gid_hist[h0] != 0) begin
      errors++; $display("FAIL rst_first_grant: got %0d, required 0", (gid_hist.size() > h0) ? gid_hist[h0] : -1);
    end
  endtask

  task automatic test_single();
    bit done;
    int w0, h0;
    busy_len = 20;
    w0 = wr_count;
    h0 = gid_hist.size();
    push_byte(2, 8'h41, 1'b0, 1'b1);
    push_byte(2, 8'h42, 1'b0, 1'b1);
    push_byte(2, 8'h43, 1'b1, 1'b1);
    wait_drain(1000, done);
    checks++; if (!done) begin errors++; $display("FAIL single_drain: got no drain, required drain"); end
    checks++; if (wr_count - w0 != 3) begin errors++; $display("FAIL single_wr_count: got %0d, required 3", wr_count - w0); end
    checks++;
    if (gid_hist.size() != h0 + 1 || gid_hist[h0] != 2) begin
      errors++; $display("FAIL single_grant: got %0d grants, required one grant to 2", gid_hist.size() - h0);
    end
    checks++;
    if (gv_fall_cyc - last_wr_cyc != 22) begin
      errors++; $display("FAIL single_release: got %0d cycles, required 22", gv_fall_cyc - last_wr_cyc);
    end
  endtask

  task automatic test_round_robin();
    bit done;
    int h0;
    int rr_exp[6] = '{0, 1, 3, 0, 1, 3};
    int reqs[3] = '{0, 1, 3};
    apply_reset();
    busy_len = 3;
    h0 = gid_hist.size();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 3; k++)
        push_byte(reqs[k], 8'(8'h10 + p*4 + reqs[k]), 1'b1, 1'b1);
    wait_drain(1000, done);
    checks++; if (!done) begin errors++; $display("FAIL rr_drain: got no drain, required drain"); end
    checks++; if (gid_hist.size() - h0 != 6) begin errors++; $display("FAIL rr_count: got %0d, required 6", gid_hist.size() - h0); end
    for (int k = 0; k < 6; k++) begin
      if (h0 + k < gid_hist.size()) begin
        checks++;
        if (gid_hist[h0+k] != rr_exp[k]) begin
          errors++; $display("FAIL rr_order[%0d]: got %0d, required %0d", k, gid_hist[h0+k], rr_exp[k]);
        end
      end
    end
  endtask

  task automatic test_no_interleave();
    bit done;
    int v0;
    busy_len = 2 + $urandom_range(0, 4);
    v0 = ready_viol;
    push_byte(0, 8'hC0, 1'b0, 1'b1);
    push_byte(0, 8'hC1, 1'b0, 1'b1);
    push_byte(0, 8'hC2, 1'b0, 1'b1);
    push_byte(0, 8'hC3, 1'b1, 1'b1);
    push_byte(1, 8'hD0, 1'b0, 1'b1);
    push_byte(1, 8'hD1, 1'b1, 1'b1);
    wait_drain(1000, done);
    checks++; if (!done) begin errors++; $display("FAIL ni_drain: got no drain, required drain"); end
    checks++; if (ready_viol != v0) begin errors++; $display("FAIL ni_ready: got %0d bad cycles, required 0", ready_viol - v0); end
  endtask

  task automatic test_busy_latency();
    bit done;
    int hc0, n0;
    busy_en = 1'b0;
    hc0 = hi_cycles;
    n0  = wr_cyc_q.size();
    push_byte(2, 8'hE0, 1'b0, 1'b1);
    push_byte(2, 8'hE1, 1'b1, 1'b1);
    wait_drain(500, done);
    busy_en = 1'b1;
    checks++; if (!done) begin errors++; $display("FAIL bl_drain: got no drain, required drain"); end
    checks++; if (hi_cycles - hc0 != 2*BUSY_LAT) begin errors++; $display("FAIL bl_hi_cycles: got %0d, required %0d", hi_cycles - hc0, 2*BUSY_LAT); end
    checks++;
    if (wr_cyc_q.size() - n0 != 2) begin
      errors++; $display("FAIL bl_wr_count: got %0d, required 2", wr_cyc_q.size() - n0);
    end else if (wr_cyc_q[n0+1] - wr_cyc_q[n0] != BUSY_LAT + 2) begin
      errors++; $display("FAIL bl_gap: got %0d, required %0d", wr_cyc_q[n0+1] - wr_cyc_q[n0], BUSY_LAT + 2);
    end
  endtask

  task automatic test_timeout();
    bit done, seen;
    int w0, h0, n;
    apply_reset();
    busy_len = 5;
    h0 = gid_hist.size();
    push_byte(1, 8'h71, 1'b0, 1'b1);
    push_byte(3, 8'h73, 1'b1, 1'b1);
    w0 = wr_count;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin @(negedge clk); #1; seen = (wr_count != w0); end
    checks++; if (!seen) begin errors++; $display("FAIL to_first_byte: got no write, required write"); end
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin @(negedge clk); #1; seen = (state_dbg == S_SEND); end
    checks++; if (!seen) begin errors++; $display("FAIL to_reenter: got no SEND, required SEND"); end
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin @(negedge clk); #1; n++; seen = timeout_pulse; end
    checks++; if (!seen || n != PKT_TIMEOUT) begin errors++; $display("FAIL to_delay: got %0d cycles, required %0d", seen ? n : -1, PKT_TIMEOUT); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL to_release: got %b, required 0", grant_valid); end
    @(negedge clk); #1;
    checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b, required 0", timeout_pulse); end
    wait_drain(500, done);
    checks++; if (!done) begin errors++; $display("FAIL to_drain: got no drain, required drain"); end
    checks++;
    if (gid_hist.size() != h0 + 2 || gid_hist[h0] != 1 || gid_hist[h0+1] != 3) begin
      errors++; $display("FAIL to_next_grant: got %0d grants, required 1 then 3", gid_hist.size() - h0);
    end
  endtask

  task automatic test_reset_mid();
    bit done, seen;
    int w0, h0;
    busy_len = 10;
    w0 = wr_count;
    push_byte(2, 8'hA1, 1'b0, 1'b1);
    push_byte(2, 8'hA2, 1'b0, 1'b0);
    push_byte(2, 8'hA3, 1'b1, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin @(negedge clk); #1; seen = (wr_count != w0); end
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin @(negedge clk); #1; seen = (state_dbg == S_WAIT_LO); end
    checks++; if (!seen) begin errors++; $display("FAIL rm_wait_lo: got no WAIT_LO, required WAIT_LO"); end
    #2;
    rstb = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    #1;
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL rm_wr_data: got %02h, required 00", wr_data); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rm_grant_valid: got %b, required 0", grant_valid); end
    checks++; if (grant_id !== '0) begin errors++; $display("FAIL rm_grant_id: got %0d, required 0", grant_id); end
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL rm_state: got %0d, required 0", state_dbg); end
    checks++; if (req_ready !== '0 || wr_en !== 1'b0 || timeout_pulse !== 1'b0) begin
      errors++; $display("FAIL rm_strobes: got ready=%b wr_en=%b to=%b, required 0", req_ready, wr_en, timeout_pulse);
    end
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    h0 = gid_hist.size();
    push_byte(0, 8'hB0, 1'b1, 1'b1);
    push_byte(2, 8'hB2, 1'b1, 1'b1);
    wait_drain(500, done);
    checks++; if (!done) begin errors++; $display("FAIL rm_drain: got no drain, required drain"); end
    checks++;
    if (gid_hist.size() < h0 + 1 || gid_hist[h0] != 0) begin
      errors++; $display("FAIL rm_first_grant: got %0d, required 0", (gid_hist.size() > h0) ? gid_hist[h0] : -1);
    end
  endtask

  initial begin
    rstb = 1'b1;
    #2;
    rstb = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_no_interleave();
    test_busy_latency();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit channel (wr_en / wr_data / tx_busy of the UART top) among NUM_REQ byte-stream requesters.
- Round-robin arbitration at packet granularity: a grant is held from a packet's first byte through the byte flagged last, so packets from different requesters never interleave on the line.
- Sequences each byte: waits for the transmitter to go busy, then idle, before the next write.
- Sits between the host-side producers (command responder, debug printer, etc.) and the UART top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; equals ceil(log2(NUM_REQ)), minimum 1.
- BUSY_LAT, 8, maximum cycles after wr_en before tx_busy is guaranteed high. Range 1..255.
- PKT_TIMEOUT, 0, idle cycles tolerated mid-packet before the grant is forcibly released. 0 disables the timeout. Range 0..65535.

Ports:
- clk  in  1  system clock
- rstb  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the final byte of its packet
- req_ready  out  NUM_REQ  byte accepted this cycle; combinational
- wr_en  out  1  one-cycle write strobe to the UART
- wr_data  out  8  byte to the UART; valid while wr_en=1
- tx_busy  in  1  UART transmitter busy
- grant_valid  out  1  a requester currently holds the channel
- grant_id  out  ID_W  index of the current or most recent grantee
- timeout_pulse  out  1  one-cycle pulse when a grant is released by PKT_TIMEOUT

Behaviour:
- Reset values (async on rstb=0):
  - state=IDLE; wr_en=0; wr_data=0; grant_valid=0; grant_id=0; timeout_pulse=0.
  - rr_ptr=NUM_REQ-1, so requester 0 wins first; all counters 0.
  - req_ready is forced 0 while in reset.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - Register grant_id=g and grant_valid=1, and go to SEND. This costs one arbitration cycle.
  - No req_ready is asserted in IDLE.
- SEND:
  - req_ready[g] = req_valid[g] & ~tx_busy. All other req_ready bits are 0.
  - On acceptance at cycle T:
    - wr_data <= req_data[g]; wr_en=1 during T+1 only.
    - Latch last_flag <= req_last[g].
    - Go to WAIT_HI.
  - While req_valid[g]=0 and PKT_TIMEOUT≠0: the idle counter increments. Any acceptance clears it.
  - When the idle counter reaches PKT_TIMEOUT:
    - timeout_pulse=1 for one cycle; grant_valid=0; rr_ptr=g; go to IDLE.
- WAIT_HI:
  - Counter starts at 0 on entry (cycle T+1).
  - Exit to WAIT_LO on the first cycle tx_busy=1, or once the counter reaches BUSY_LAT.
  - Counter saturates and never wraps.
- WAIT_LO:
  - On the first cycle tx_busy=0:
    - If last_flag=1: rr_ptr=g, grant_valid=0, go to IDLE.
    - Otherwise go to SEND.
- Throughput: at most one byte accepted per transmitter frame. The minimum gap between wr_en pulses is 3 cycles (accept, WAIT_HI, WAIT_LO) plus the transmitter's busy time.
- Simultaneous events:
  - A non-granted requester asserting valid never affects the current packet.
  - A granted requester dropping valid with ready=0 is legal.
  - Data must stay stable while valid=1 and ready=0.
- tx_busy already high in SEND stalls acceptance; the byte is not lost.
- grant_id holds its last value after release; it is meaningful only when grant_valid=1.
- Reset mid-byte: all state clears at once. Bytes not yet strobed are discarded; the UART itself is reset by the same rstb.
- Requester indices ≥ NUM_REQ do not exist; no out-of-range grant is possible.

Test Plan:
- Single request: req 2 sends a 3-byte packet 0x41, 0x42, 0x43 (last on 0x43), tx_busy modeled 20 cycles high starting 1 cycle after wr_en:
  - Expect exactly 3 wr_en pulses with those bytes in order.
  - grant_id=2 throughout; grant_valid drops after the busy period of 0x43 ends.
- Round robin: reqs 0, 1 and 3 all hold 1-byte packets (last=1) continuously → grant order 0, 1, 3, 0, 1, 3; req 2 is never granted.
- No interleave: req 0 sends a 4-byte packet with req 1 valid throughout → all 4 bytes of req 0 are strobed before any byte of req 1; req_ready[1]=0 during the packet.
- Busy latency: tx_busy never rises after wr_en, BUSY_LAT=8 → WAIT_HI exits after 8 cycles and the next byte is accepted; no deadlock.
- Timeout: PKT_TIMEOUT=16, req 1 sends one non-last byte then drops valid, req 3 is pending:
  - timeout_pulse fires 16 cycles after SEND re-entry.
  - req 3 is granted next.
- Reset mid-packet: rstb pulsed low during WAIT_LO → all outputs return to reset values asynchronously. After release, req 0 wins first arbitration.
